// File: rtl/paddle_if.sv
// Paddle controller signal bundle: step pulses and frame tick in,
// registered position and status flags out.
interface paddle_if #(
  parameter int POS_W = 10
);
  logic             left_op;
  logic             right_op;
  logic             frame_tick;
  logic [POS_W-1:0] paddle_x;
  logic             moving;
  logic             at_left;
  logic             at_right;

  modport master (
    output left_op, right_op, frame_tick,
    input  paddle_x, moving, at_left, at_right
  );

  modport slave (
    input  left_op, right_op, frame_tick,
    output paddle_x, moving, at_left, at_right
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle position controller: queues left/right step pulses in a saturating
// signed pending count and spends one queued step per video frame.
module paddle_ctrl #(
  parameter int POS_W    = 10,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 560,
  parameter int POS_INIT = 280,
  parameter int STEP     = 8,
  parameter int PEND_MAX = 7
) (
  input  logic     clk,
  input  logic     rst,
  paddle_if.slave  bus
);

  // Pending count storage, plus two guard bits for the pend+-1+delta sum.
  localparam int PEND_W = $clog2(PEND_MAX + 1) + 1;
  localparam int PA_W   = PEND_W + 2;

  localparam logic signed [PA_W-1:0] P_ONE  = PA_W'(1);
  localparam logic signed [PA_W-1:0] N_ONE  = -P_ONE;
  localparam logic signed [PA_W-1:0] P_ZERO = '0;
  localparam logic signed [PA_W-1:0] P_MAX  = PA_W'(PEND_MAX);
  localparam logic signed [PA_W-1:0] P_MIN  = -P_MAX;

  localparam logic [POS_W:0]   STEP_X = (POS_W + 1)'(STEP);
  localparam logic [POS_W:0]   MAX_X  = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0]   MIN_X  = (POS_W + 1)'(POS_MIN);
  localparam logic [POS_W-1:0] MAX_P  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] MIN_P  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] INIT_P = POS_W'(POS_INIT);
  localparam logic AT_L_INIT = (POS_INIT == POS_MIN);
  localparam logic AT_R_INIT = (POS_INIT == POS_MAX);

  typedef enum logic [1:0] {IDLE, MOVE_R, MOVE_L} state_t;

  state_t                    state, state_nxt;
  logic signed [PEND_W-1:0]  pend, pend_nxt;
  logic [POS_W-1:0]          pos, pos_nxt;
  logic                      moving_q, at_left_q, at_right_q;

  logic signed [PA_W-1:0]    delta, pend_ext, pend_sum;
  logic [POS_W:0]            pos_up, pos_dn;
  logic                      hit_r, hit_l;

  function automatic logic signed [PEND_W-1:0] sat(input logic signed [PA_W-1:0] v);
    if (v > P_MAX)      return PEND_W'(P_MAX);
    else if (v < P_MIN) return PEND_W'(P_MIN);
    else                return PEND_W'(v);
  endfunction

  // One-bit-wider position math so neither direction wraps before clamping.
  assign pos_up = {1'b0, pos} + STEP_X;
  assign pos_dn = {1'b0, pos} - STEP_X;
  assign hit_r  = (pos_up >= MAX_X);
  assign hit_l  = ({1'b0, pos} < STEP_X) || (pos_dn <= MIN_X);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pos_nxt  = pos;
    pend_ext = {{(PA_W - PEND_W){pend[PEND_W-1]}}, pend};
    delta    = P_ZERO;
    if (bus.right_op && !bus.left_op)      delta = P_ONE;
    else if (bus.left_op && !bus.right_op) delta = N_ONE;
    pend_sum = pend_ext + delta;

    if (bus.frame_tick) begin
      unique case (state)
        MOVE_R: begin
          if (hit_r) begin
            pos_nxt  = MAX_P;
            pend_sum = delta;
          end else begin
            pos_nxt  = pos_up[POS_W-1:0];
            pend_sum = pend_ext - P_ONE + delta;
          end
        end
        MOVE_L: begin
          if (hit_l) begin
            pos_nxt  = MIN_P;
            pend_sum = delta;
          end else begin
            pos_nxt  = pos_dn[POS_W-1:0];
            pend_sum = pend_ext + P_ONE + delta;
          end
        end
        default: pend_sum = delta;
      endcase
    end

    pend_nxt = sat(pend_sum);
    if (pend_nxt > 0)      state_nxt = MOVE_R;
    else if (pend_nxt < 0) state_nxt = MOVE_L;
    else                   state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      pos        <= INIT_P;
      moving_q   <= 1'b0;
      at_left_q  <= AT_L_INIT;
      at_right_q <= AT_R_INIT;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      pos        <= pos_nxt;
      moving_q   <= (pend_nxt != '0);
      at_left_q  <= (pos_nxt == MIN_P);
      at_right_q <= (pos_nxt == MAX_P);
    end
  end

  assign bus.paddle_x = pos;
  assign bus.moving   = moving_q;
  assign bus.at_left  = at_left_q;
  assign bus.at_right = at_right_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus biased random pulses,
// all compared against an integer model of the paddle rules.
module tb_paddle_ctrl;

  localparam int POS_W    = 10;
  localparam int POS_MIN  = 0;
  localparam int POS_MAX  = 560;
  localparam int POS_INIT = 280;
  localparam int STEP     = 8;
  localparam int PEND_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int m_pos  = POS_INIT;
  int m_pend = 0;

  paddle_if #(.POS_W(POS_W)) bus ();

  paddle_ctrl #(
    .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
    .POS_INIT(POS_INIT), .STEP(STEP), .PEND_MAX(PEND_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    if (v > PEND_MAX)  return PEND_MAX;
    if (v < -PEND_MAX) return -PEND_MAX;
    return v;
  endfunction

  // Apply one clock's worth of the paddle rules to the model.
  task automatic model_cycle(input logic l, input logic r, input logic t, input logic rs);
    int d;
    int np;
    d = (r && !l) ? 1 : (l && !r) ? -1 : 0;
    if (rs) begin
      m_pos  = POS_INIT;
      m_pend = 0;
    end else if (t && m_pend > 0) begin
      np = m_pos + STEP;
      if (np >= POS_MAX) begin m_pos = POS_MAX; m_pend = d; end
      else begin m_pos = np; m_pend = clip(m_pend - 1 + d); end
    end else if (t && m_pend < 0) begin
      np = m_pos - STEP;
      if (np <= POS_MIN) begin m_pos = POS_MIN; m_pend = d; end
      else begin m_pos = np; m_pend = clip(m_pend + 1 + d); end
    end else begin
      m_pend = clip(m_pend + d);
    end
  endtask

  task automatic step(input logic l, input logic r, input logic t, input logic rs);
    bus.left_op    = l;
    bus.right_op   = r;
    bus.frame_tick = t;
    rst            = rs;
    @(posedge clk);
    model_cycle(l, r, t, rs);
    #1;
    check("paddle_x", int'(bus.paddle_x), m_pos);
    check("moving",   int'(bus.moving),   int'(m_pend != 0));
    check("at_left",  int'(bus.at_left),  int'(m_pos == POS_MIN));
    check("at_right", int'(bus.at_right), int'(m_pos == POS_MAX));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bus.left_op    = 1'b0;
    bus.right_op   = 1'b0;
    bus.frame_tick = 1'b0;

    // Reset state
    do_reset();
    check("rst_x",      int'(bus.paddle_x), 280);
    check("rst_moving", int'(bus.moving),   0);
    check("rst_atl",    int'(bus.at_left),  0);
    check("rst_atr",    int'(bus.at_right), 0);

    // Three right pulses, then three ticks
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("r3_moving", int'(bus.moving), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0); check("r3_t1", int'(bus.paddle_x), 288);
    step(1'b0, 1'b0, 1'b1, 1'b0); check("r3_t2", int'(bus.paddle_x), 296);
    step(1'b0, 1'b0, 1'b1, 1'b0); check("r3_t3", int'(bus.paddle_x), 304);
    check("r3_idle", int'(bus.moving), 0);

    // Left saturation at -7
    do_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("lsat_x", int'(bus.paddle_x), 224);
    check("lsat_moving", int'(bus.moving), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("lsat_x8", int'(bus.paddle_x), 224);

    // Walk to 552, queue 5 right steps, tick into the right boundary
    do_reset();
    repeat (34) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("walk_x", int'(bus.paddle_x), 552);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("bnd_x",      int'(bus.paddle_x), 560);
    check("bnd_atr",    int'(bus.at_right), 1);
    check("bnd_moving", int'(bus.moving),   0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("bnd_hold", int'(bus.paddle_x), 560);

    // Simultaneous pulses cancel
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("both_idle_x", int'(bus.paddle_x), 280);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("both_pend2_x", int'(bus.paddle_x), 296);

    // Opposite pulse together with a tick
    do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("opp_x",      int'(bus.paddle_x), 288);
    check("opp_moving", int'(bus.moving),   0);

    // Reset mid-move wins over a tick
    do_reset();
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("rstmv_x",      int'(bus.paddle_x), 280);
    check("rstmv_moving", int'(bus.moving),   0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rstmv_after", int'(bus.paddle_x), 280);

    // Biased random walk, drifting toward each wall in turn
    for (int i = 0; i < 4000; i++) begin
      logic bias_r, l, r, t, rs;
      bias_r = ((i / 500) % 2) == 0;
      l  = $urandom_range(0, 99) < (bias_r ? 12 : 40);
      r  = $urandom_range(0, 99) < (bias_r ? 40 : 12);
      t  = $urandom_range(0, 3) == 0;
      rs = $urandom_range(0, 299) == 0;
      step(l, r, t, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
